// File: rtl/hlsm_avg_n_if.sv
// hlsm_avg_n_if: Start/Done job handshake carrying packed operands, shift amount and result
interface hlsm_avg_n_if #(
  parameter int WIDTH  = 33,
  parameter int NUM_IN = 8,
  parameter int SAW    = 6
);
  logic                    Start;
  logic [NUM_IN*WIDTH-1:0] x;
  logic [SAW-1:0]          sa;
  logic                    Busy;
  logic                    Done;
  logic [WIDTH-1:0]        avg;
  logic                    Ovf;
  modport master (output Start, x, sa, input Busy, Done, avg, Ovf);
  modport slave  (input Start, x, sa, output Busy, Done, avg, Ovf);
endinterface

// File: rtl/hlsm_avg_n.sv
// hlsm_avg_n: multi-cycle sum of NUM_IN operands followed by NUM_SHIFT right-shifts, Start/Done handshake
module hlsm_avg_n #(
  parameter int WIDTH     = 33,
  parameter int NUM_IN    = 8,
  parameter int NUM_SHIFT = 3,
  parameter int SAW       = 6,
  parameter int SIGNED    = 0
) (
  input logic         Clk,
  input logic         Rst,
  hlsm_avg_n_if.slave bus
);
  localparam int ACCW = WIDTH + $clog2(NUM_IN);
  localparam int IW   = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  localparam int CW   = NUM_SHIFT > 1 ? $clog2(NUM_SHIFT) : 1;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FINAL} state_t;
  state_t                  state;
  logic [NUM_IN*WIDTH-1:0] x_q;
  logic [SAW-1:0]          sa_q;
  logic [ACCW-1:0]         acc;
  logic [ACCW-1:0]         sh;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        ops [NUM_IN];
  logic                    ovf_n;
  function automatic logic [ACCW-1:0] ext(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) return ACCW'($signed(v));
    return ACCW'(v);
  endfunction
  // unpack the latched operand bus into an indexable array
  always_comb
    for (int i = 0; i < NUM_IN; i++) ops[i] = x_q[i*WIDTH +: WIDTH];
  // one shift stage; oversize amounts saturate to zero or to the sign fill
  always_comb
    if (32'(sa_q) >= ACCW) sh = {ACCW{SIGNED != 0 && acc[ACCW-1]}};
    else if (SIGNED != 0) sh = ACCW'($signed(acc) >>> sa_q);
    else sh = acc >> sa_q;
  if (ACCW == WIDTH) begin : g_noovf
    assign ovf_n = 1'b0;
  end else if (SIGNED != 0) begin : g_sovf
    assign ovf_n = !(&sh[ACCW-1:WIDTH-1] || !(|sh[ACCW-1:WIDTH-1]));
  end else begin : g_uovf
    assign ovf_n = |sh[ACCW-1:WIDTH];
  end
  // job sequencer: latch on Start, accumulate, shift, publish the result on the last shift
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state    <= IDLE;
      x_q      <= '0;
      sa_q     <= '0;
      acc      <= '0;
      idx      <= '0;
      cnt      <= '0;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
      bus.avg  <= '0;
      bus.Ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, FINAL: begin
          bus.Done <= 1'b0;
          if (bus.Start) begin
            x_q      <= bus.x;
            sa_q     <= bus.sa;
            acc      <= ext(bus.x[WIDTH-1:0]);
            idx      <= IW'(1);
            cnt      <= '0;
            bus.Busy <= 1'b1;
            state    <= NUM_IN == 1 ? SHIFT : ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          acc <= acc + ext(ops[idx]);
          idx <= idx + 1'b1;
          if (idx == IW'(NUM_IN - 1)) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= sh;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NUM_SHIFT - 1)) begin
            bus.avg  <= sh[WIDTH-1:0];
            bus.Ovf  <= ovf_n;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b1;
            state    <= FINAL;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hlsm_avg_n.sv
// tb_hlsm_avg_n: table, random and sequence checks of unsigned default and signed small averagers
module tb_hlsm_avg_n;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  always #5 Clk = ~Clk;
  hlsm_avg_n_if #(.WIDTH(33), .NUM_IN(8), .SAW(6)) i0 ();
  hlsm_avg_n_if #(.WIDTH(8),  .NUM_IN(4), .SAW(6)) i1 ();
  hlsm_avg_n #(.WIDTH(33), .NUM_IN(8), .NUM_SHIFT(3), .SAW(6), .SIGNED(0)) d0 (.Clk(Clk), .Rst(Rst), .bus(i0.slave));
  hlsm_avg_n #(.WIDTH(8),  .NUM_IN(4), .NUM_SHIFT(3), .SAW(6), .SIGNED(1)) d1 (.Clk(Clk), .Rst(Rst), .bus(i1.slave));
  typedef struct {
    bit           s;
    logic [263:0] x;
    logic [5:0]   sa;
    logic [32:0]  avg;
    bit           ovf;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  // mathematical reference: exact integer sum, floor-divide by 2^sa three times, then range check
  function automatic logic [33:0] model(input bit s, input logic [263:0] xv, input logic [5:0] sav);
    longint v = 0;
    if (s) for (int k = 0; k < 4; k++) v += longint'($signed(xv[k*8 +: 8]));
    else   for (int k = 0; k < 8; k++) v += longint'(xv[k*33 +: 33]);
    for (int k = 0; k < 3; k++) v = v >>> sav;
    if (s) return {(v < -128 || v > 127), 25'b0, v[7:0]};
    return {((v >> 33) != 0), v[32:0]};
  endfunction
  task automatic check_job(input string nm, input bit s, input logic [263:0] xv, input logic [5:0] sav,
                           input logic [32:0] ea, input bit eo);
    int lat, bz;
    logic [32:0] a;
    bit o, d;
    @(negedge Clk);
    if (s) begin i1.Start = 1'b1; i1.x = xv[31:0]; i1.sa = sav; end
    else   begin i0.Start = 1'b1; i0.x = xv;       i0.sa = sav; end
    @(posedge Clk); #1;
    i0.Start = 1'b0; i1.Start = 1'b0;
    i0.x = ~i0.x; i1.x = ~i1.x; i0.sa = ~i0.sa; i1.sa = ~i1.sa;
    lat = 0; bz = 0;
    while (!(s ? i1.Done : i0.Done) && lat < 40) begin
      bz += int'(s ? i1.Busy : i0.Busy);
      @(posedge Clk); #1;
      lat++;
    end
    a = s ? 33'(i1.avg) : i0.avg;
    o = s ? i1.Ovf : i0.Ovf;
    @(posedge Clk); #1;
    d = s ? i1.Done : i0.Done;
    chk({nm, " avg"},     64'(a),   64'(ea));
    chk({nm, " ovf"},     64'(o),   64'(eo));
    chk({nm, " latency"}, 64'(lat), s ? 64'd6 : 64'd10);
    chk({nm, " busy"},    64'(bz),  s ? 64'd6 : 64'd10);
    chk({nm, " done1"},   64'(d),   64'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [263:0] seq, xa, xb, xc;
    logic [33:0]  m, ma, mb;
    logic [32:0]  ra, rb;
    bit           ro, rbo, b11, b23;
    int           t1, t2, nd;
    seq = '0;
    for (int k = 0; k < 8; k++) seq[k*33 +: 33] = 33'(k + 1);
    tbl[0] = '{0, seq,                       6'd1,  33'd4,           1'b0};
    tbl[1] = '{0, {8{33'h1_FFFF_FFFF}},      6'd0,  33'h1_FFFF_FFF8, 1'b1};
    tbl[2] = '{0, {8{33'h1_FFFF_FFFF}},      6'd1,  33'h1_FFFF_FFFF, 1'b0};
    tbl[3] = '{0, seq,                       6'd63, 33'd0,           1'b0};
    tbl[4] = '{0, {8{33'h100}},              6'd1,  33'h100,         1'b0};
    tbl[5] = '{1, 264'({8'hF9, 8'hF8, 8'hF8, 8'hF8}), 6'd1, 33'hFC,  1'b0};
    tbl[6] = '{1, 264'({4{8'h7F}}),          6'd0,  33'hFC,          1'b1};
    tbl[7] = '{1, 264'({4{8'd100}}),         6'd1,  33'h32,          1'b0};
    tbl[8] = '{1, 264'({4{8'hF8}}),          6'd63, 33'hFF,          1'b0};
    tbl[9] = '{1, 264'({4{8'h80}}),          6'd0,  33'h00,          1'b1};
    i0.Start = 1'b0; i0.x = '0; i0.sa = '0;
    i1.Start = 1'b0; i1.x = '0; i1.sa = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset done",  64'(i0.Done), 64'd0);
    chk("reset busy",  64'(i0.Busy), 64'd0);
    chk("reset avg",   64'(i0.avg),  64'd0);
    chk("reset ovf",   64'(i0.Ovf),  64'd0);
    chk("reset avg s", 64'(i1.avg),  64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 10; i++)
      check_job($sformatf("tbl%0d", i), tbl[i].s, tbl[i].x, tbl[i].sa, tbl[i].avg, tbl[i].ovf);
    for (int i = 0; i < 30; i++) begin
      logic [263:0] xv;
      logic [5:0]   sav;
      int           r;
      bit           s;
      s = bit'(i % 2);
      for (int k = 0; k < 9; k++) xv[k*32 +: 32] = $urandom;
      if (s) xv[263:32] = '0;
      else   xv[263:264-8] = '0;
      r   = $urandom_range(0, 9);
      sav = r < 7 ? 6'($urandom_range(0, 4)) : r == 7 ? 6'd63 : 6'($urandom_range(0, 63));
      m   = model(s, xv, sav);
      check_job($sformatf("rnd%0d", i), s, xv, sav, m[32:0], m[33]);
    end
    for (int k = 0; k < 9; k++) begin xa[k*32 +: 32] = $urandom; xb[k*32 +: 32] = $urandom; xc[k*32 +: 32] = $urandom; end
    xa[263:264-8] = '0; xb[263:264-8] = '0;
    ma = model(0, xa, 6'd1);
    mb = model(0, xb, 6'd2);
    @(negedge Clk);
    i0.Start = 1'b1; i0.x = xa; i0.sa = 6'd1;
    @(posedge Clk); #1;
    i0.x = xb; i0.sa = 6'd2;
    t1 = -1; t2 = -1; nd = 0; ra = '0; rb = '0; ro = 1'b0; rbo = 1'b0; b11 = 1'b0; b23 = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge Clk); #1;
      if (i0.Done) begin
        nd++;
        if (t1 < 0) begin t1 = c; ra = i0.avg; ro = i0.Ovf; end
        else if (t2 < 0) begin t2 = c; rb = i0.avg; rbo = i0.Ovf; end
      end
      if (c == 11) begin b11 = i0.Busy; i0.Start = 1'b0; i0.x = xc; i0.sa = 6'd0; end
      if (c == 13) i0.Start = 1'b1;
      if (c == 14) i0.Start = 1'b0;
      if (c == 23) b23 = i0.Busy;
    end
    chk("b2b first done",  64'(t1),      64'd10);
    chk("b2b second done", 64'(t2 - t1), 64'd11);
    chk("b2b done count",  64'(nd),      64'd2);
    chk("b2b busy job2",   64'(b11),     64'd1);
    chk("b2b no job3",     64'(b23),     64'd0);
    chk("b2b avg1",        64'(ra),      64'(ma[32:0]));
    chk("b2b ovf1",        64'(ro),      64'(ma[33]));
    chk("b2b avg2",        64'(rb),      64'(mb[32:0]));
    chk("b2b ovf2",        64'(rbo),     64'(mb[33]));
    check_job("pre-reset", 0, {8{33'h1_FFFF_FFFF}}, 6'd0, 33'h1_FFFF_FFF8, 1'b1);
    @(negedge Clk);
    i0.Start = 1'b1; i0.x = seq; i0.sa = 6'd0;
    @(posedge Clk); #1;
    i0.Start = 1'b0;
    repeat (8) @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    chk("async rst done", 64'(i0.Done), 64'd0);
    chk("async rst busy", 64'(i0.Busy), 64'd0);
    chk("async rst avg",  64'(i0.avg),  64'd0);
    chk("async rst ovf",  64'(i0.Ovf),  64'd0);
    nd = 0;
    repeat (3) begin @(posedge Clk); #1; nd += int'(i0.Done); end
    chk("rst no done", 64'(nd), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    check_job("post-reset", 0, seq, 6'd1, 33'd4, 1'b0);
    check_job("post-reset s", 1, 264'({8'hF9, 8'hF8, 8'hF8, 8'hF8}), 6'd1, 33'hFC, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
